ospfb_seq_ctrl: RTL and testbench

Single-clock sequencer for the oversampled PFB datapath in the DSP clock domain. It holds the FIR/FFT pipeline in reset long enough to flush it, then sends one configuration word to the FFT core over AXI-Stream. Once the FFT is ready it opens the input gate and tracks frame boundaries to produce the phase-compensation rotation offset. It monitors the FFT event flags and re-synchronises the whole chain on a framing fault.

---
 rtl/alpaca_ospfb_constants_pkg.sv | 28 ++
 rtl/ospfb_phase_ctr.sv | 55 +++++
 rtl/ospfb_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ospfb_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared constants and types for the OSPFB sequencing logic.
package alpaca_ospfb_constants_pkg;

    // Sequencer FSM states; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        INIT    = 3'd0,
        CONFIG  = 3'd1,
        WAITFFT = 3'd2,
        RUN     = 3'd3
    } ospfb_ctrl_state_t;

    localparam int unsigned FFT_LEN_DEFAULT = 2048;
    localparam int unsigned PTAPS_DEFAULT   = 8;

    // Cycles needed to flush the polyphase FIR: one full transform per tap.
    function automatic int unsigned flush_cycles(input int unsigned fft_len,
                                                 input int unsigned ptaps);
        return fft_len * ptaps;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned FLUSH = flush_cycles(FFT_LEN_DEFAULT, PTAPS_DEFAULT);

endpackage

// File: rtl/ospfb_phase_ctr.sv
// Frame counter and modular phase accumulator for OSPFB phase compensation.
module ospfb_phase_ctr
    import alpaca_ospfb_constants_pkg::*;
#(
    parameter int unsigned FFT_LEN = 2048,
    parameter int unsigned DEC_FAC = 1536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       fir_vld,
    output logic                       frame_last,
    output logic [$clog2(FFT_LEN)-1:0] phase
);

    localparam int unsigned PHASE_W = $clog2(FFT_LEN);
    localparam int unsigned SUM_W   = PHASE_W + 1;

    logic [PHASE_W-1:0] frame_cnt;
    logic [SUM_W-1:0]   phase_sum_c;
    logic [PHASE_W-1:0] phase_wrap_c;
    logic               last_vld_c;

    // Next phase is phase + DEC_FAC reduced modulo FFT_LEN, using one extra bit.
    always_comb begin
        phase_sum_c  = {1'b0, phase} + SUM_W'(DEC_FAC);
        phase_wrap_c = PHASE_W'(phase_sum_c);
        if (phase_sum_c >= SUM_W'(FFT_LEN)) begin
            phase_wrap_c = PHASE_W'(phase_sum_c - SUM_W'(FFT_LEN));
        end
        last_vld_c = fir_vld && (frame_cnt == PHASE_W'(FFT_LEN - 1));
    end

    // Count valid samples, flag the frame end and advance the phase once per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt  <= '0;
            phase      <= '0;
            frame_last <= 1'b0;
        end else if (clear) begin
            frame_cnt  <= '0;
            phase      <= '0;
            frame_last <= 1'b0;
        end else begin
            frame_last <= last_vld_c;
            if (fir_vld) begin
                frame_cnt <= frame_cnt + PHASE_W'(1);
            end
            if (last_vld_c) begin
                phase <= phase_wrap_c;
            end
        end
    end

endmodule

// File: rtl/ospfb_seq_ctrl.sv
// Sequencer for the OSPFB datapath: flush, configure the FFT, gate input,
// track frame phase and re-synchronise on FFT framing faults.
module ospfb_seq_ctrl
    import alpaca_ospfb_constants_pkg::*;
#(
    parameter int unsigned          FFT_LEN   = 2048,
    parameter int unsigned          DEC_FAC   = 1536,
    parameter int unsigned          PTAPS     = 8,
    parameter int unsigned          CONF_WID  = 16,
    parameter logic                 FWD_INV   = 1'b1,
    parameter logic [CONF_WID-2:0]  SCALE_SCH = '0,
    parameter int unsigned          CFG_WAIT  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    output logic [CONF_WID-1:0]        m_axis_config_tdata,
    output logic                       m_axis_config_tvalid,
    input  logic                       m_axis_config_tready,
    output logic                       hold_rst,
    output logic                       din_en,
    input  logic                       fir_vld,
    output logic                       frame_last,
    output logic [$clog2(FFT_LEN)-1:0] phase,
    input  logic                       event_tlast_unexpected,
    input  logic                       event_tlast_missing,
    input  logic                       event_fft_overflow,
    input  logic                       event_data_in_channel_halt,
    output logic [2:0]                 state,
    output logic [15:0]                err_count,
    output logic                       ovf_sticky
);

    localparam int unsigned FLUSH_CYC = flush_cycles(FFT_LEN, PTAPS);
    localparam int unsigned FLUSH_W   = cnt_width(FLUSH_CYC);
    // A zero wait still spends one cycle in WAITFFT.
    localparam int unsigned WAIT_CYC  = (CFG_WAIT > 0) ? CFG_WAIT : 1;
    localparam int unsigned WAIT_W    = cnt_width(WAIT_CYC);
    localparam int unsigned ERR_W     = 16;
    localparam logic [ERR_W-1:0]    ERR_MAX  = '1;
    localparam logic [CONF_WID-1:0] CFG_WORD = {SCALE_SCH, FWD_INV};

    ospfb_ctrl_state_t st_q, st_d;

    logic [FLUSH_W-1:0]  flush_cnt, flush_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
    logic [ERR_W-1:0]    err_d;
    logic [CONF_WID-1:0] cfg_data_d;
    logic                cfg_vld_d;
    logic                hold_rst_d;
    logic                din_en_d;
    logic                ovf_d;
    logic                flush_done_c;
    logic                wait_done_c;
    logic                cfg_hs_c;
    logic                fault_c;
    logic                run_vld_c;

    assign state = st_q;

    // Next state, next counter values and next registered outputs.
    always_comb begin
        st_d        = st_q;
        flush_cnt_d = '0;
        wait_cnt_d  = '0;

        flush_done_c = (flush_cnt == FLUSH_W'(FLUSH_CYC - 1));
        wait_done_c  = (wait_cnt == WAIT_W'(WAIT_CYC - 1));
        cfg_hs_c     = m_axis_config_tvalid && m_axis_config_tready;
        // Simultaneous framing events collapse into a single fault.
        fault_c      = (st_q == RUN) && (event_tlast_unexpected ||
                                         event_tlast_missing ||
                                         event_data_in_channel_halt);
        run_vld_c    = fir_vld && (st_q == RUN);

        case (st_q)
            INIT: begin
                // Counter saturates at the last flush cycle while en is low.
                flush_cnt_d = flush_done_c ? flush_cnt : flush_cnt + FLUSH_W'(1);
                if (flush_done_c && en) begin
                    st_d = CONFIG;
                end
            end
            CONFIG: begin
                if (cfg_hs_c) begin
                    st_d = WAITFFT;
                end
            end
            WAITFFT: begin
                wait_cnt_d = wait_done_c ? '0 : wait_cnt + WAIT_W'(1);
                if (wait_done_c) begin
                    st_d = RUN;
                end
            end
            RUN: begin
                if (fault_c) begin
                    st_d = INIT;
                end
            end
            default: begin
                st_d = INIT;
            end
        endcase

        hold_rst_d = (st_d == INIT);
        din_en_d   = (st_d == RUN) && en;
        cfg_vld_d  = (st_d == CONFIG);
        cfg_data_d = (st_d == CONFIG) ? CFG_WORD : m_axis_config_tdata;

        // Increment beats a coincident clear.
        err_d = err_count;
        if (fault_c) begin
            if (err_count != ERR_MAX) begin
                err_d = err_count + ERR_W'(1);
            end
        end else if (clr) begin
            err_d = '0;
        end

        ovf_d = event_fft_overflow || (ovf_sticky && !clr);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q                 <= INIT;
            flush_cnt            <= '0;
            wait_cnt             <= '0;
            hold_rst             <= 1'b1;
            din_en               <= 1'b0;
            m_axis_config_tvalid <= 1'b0;
            m_axis_config_tdata  <= '0;
            err_count            <= '0;
            ovf_sticky           <= 1'b0;
        end else begin
            st_q                 <= st_d;
            flush_cnt            <= flush_cnt_d;
            wait_cnt             <= wait_cnt_d;
            hold_rst             <= hold_rst_d;
            din_en               <= din_en_d;
            m_axis_config_tvalid <= cfg_vld_d;
            m_axis_config_tdata  <= cfg_data_d;
            err_count            <= err_d;
            ovf_sticky           <= ovf_d;
        end
    end

    // Frame/phase tracking runs only in RUN and restarts on a fault.
    ospfb_phase_ctr #(
        .FFT_LEN (FFT_LEN),
        .DEC_FAC (DEC_FAC)
    ) u_phase_ctr (
        .clk        (clk),
        .rst        (rst),
        .clear      (fault_c),
        .fir_vld    (run_vld_c),
        .frame_last (frame_last),
        .phase      (phase)
    );

endmodule

// File: tb/tb_ospfb_seq_ctrl.sv
// Scoreboard bench for ospfb_seq_ctrl with the small test configuration.
module tb_ospfb_seq_ctrl;

    localparam int FFT_LEN  = 64;
    localparam int DEC_FAC  = 48;
    localparam int PTAPS    = 8;
    localparam int CFG_WAIT = 16;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [15:0] m_axis_config_tdata;
    logic        m_axis_config_tvalid;
    logic        m_axis_config_tready;
    logic        hold_rst;
    logic        din_en;
    logic        fir_vld;
    logic        frame_last;
    logic [5:0]  phase;
    logic        event_tlast_unexpected;
    logic        event_tlast_missing;
    logic        event_fft_overflow;
    logic        event_data_in_channel_halt;
    logic [2:0]  state;
    logic [15:0] err_count;
    logic        ovf_sticky;

    typedef struct {
        int ph;
        int gap;
    } fexp_t;

    fexp_t fq[$];
    int    cq[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    last_fl = 0;
    int    n;

    ospfb_seq_ctrl #(
        .FFT_LEN  (FFT_LEN),
        .DEC_FAC  (DEC_FAC),
        .PTAPS    (PTAPS),
        .CONF_WID (16),
        .FWD_INV  (1'b1),
        .SCALE_SCH(15'd0),
        .CFG_WAIT (CFG_WAIT)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .en                         (en),
        .clr                        (clr),
        .m_axis_config_tdata        (m_axis_config_tdata),
        .m_axis_config_tvalid       (m_axis_config_tvalid),
        .m_axis_config_tready       (m_axis_config_tready),
        .hold_rst                   (hold_rst),
        .din_en                     (din_en),
        .fir_vld                    (fir_vld),
        .frame_last                 (frame_last),
        .phase                      (phase),
        .event_tlast_unexpected     (event_tlast_unexpected),
        .event_tlast_missing        (event_tlast_missing),
        .event_fft_overflow         (event_fft_overflow),
        .event_data_in_channel_halt (event_data_in_channel_halt),
        .state                      (state),
        .err_count                  (err_count),
        .ovf_sticky                 (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a frame end or a config beat.
    initial begin
        fexp_t fe;
        int    ce;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (frame_last) begin
                    if (fq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL frame_unexpected: got phase %0d expected no frame_last (cycle %0d)", phase, cyc);
                    end else begin
                        fe = fq.pop_front();
                        chk("frame_phase", int'(phase), fe.ph);
                        if (fe.gap != 0) chk("frame_gap", cyc - last_fl, fe.gap);
                    end
                    last_fl = cyc;
                end
                if (m_axis_config_tvalid && m_axis_config_tready) begin
                    if (cq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL cfg_unexpected: got tdata %0d expected no handshake (cycle %0d)", m_axis_config_tdata, cyc);
                    end else begin
                        ce = cq.pop_front();
                        chk("cfg_tdata", int'(m_axis_config_tdata), ce);
                    end
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Count edges until hold_rst drops, bounded.
    task automatic wait_flush(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (hold_rst && cnt < 2000);
    endtask

    // Release config with tready and count edges (handshake edge included) until din_en.
    task automatic do_handshake(output int cnt);
        @(negedge clk);
        cq.push_back(1);
        m_axis_config_tready = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1) begin
                chk("tvalid_after_hs", int'(m_axis_config_tvalid), 0);
                chk("state_waitfft", int'(state), 2);
            end
        end while (!din_en && cnt < 100);
        @(negedge clk);
        m_axis_config_tready = 1'b0;
    endtask

    task automatic drive_vld(input int cnt, input int period);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            fir_vld = ((i % period) == 0);
        end
        @(negedge clk);
        fir_vld = 1'b0;
    endtask

    task automatic push_frame(input int ph, input int gap);
        fexp_t e;
        e.ph  = ph;
        e.gap = gap;
        fq.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        clr = 1'b0;
        m_axis_config_tready = 1'b0;
        fir_vld = 1'b0;
        event_tlast_unexpected = 1'b0;
        event_tlast_missing = 1'b0;
        event_fft_overflow = 1'b0;
        event_data_in_channel_halt = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_hold_rst", int'(hold_rst), 1);
        chk("rst_din_en", int'(din_en), 0);
        chk("rst_tvalid", int'(m_axis_config_tvalid), 0);
        chk("rst_tdata", int'(m_axis_config_tdata), 0);
        chk("rst_frame_last", int'(frame_last), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_ovf_sticky", int'(ovf_sticky), 0);

        // Flush: hold_rst drops on the 512th edge after release
        @(negedge clk);
        rst = 1'b0;
        wait_flush(n);
        chk("flush_len", n, 512);
        chk("state_config", int'(state), 1);
        chk("tvalid_rise", int'(m_axis_config_tvalid), 1);

        // Backpressure 10 cycles, with fault flags pulsed in CONFIG (ignored)
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            event_tlast_missing = (i == 4);
            event_tlast_unexpected = (i == 4);
            event_data_in_channel_halt = (i == 4);
            @(posedge clk);
            #1;
            chk("bp_tvalid", int'(m_axis_config_tvalid), 1);
            chk("bp_tdata", int'(m_axis_config_tdata), 1);
            chk("bp_state", int'(state), 1);
        end
        chk("err_ignored_outside_run", int'(err_count), 0);

        do_handshake(n);
        chk("cfg_to_din_en", n, 17);
        chk("state_run", int'(state), 3);

        // Continuous fir_vld: four frames
        push_frame(48, 0);
        push_frame(32, 64);
        push_frame(16, 64);
        push_frame(0, 64);
        drive_vld(256, 1);
        repeat (4) @(negedge clk);

        // 50% fir_vld: two frames at 128-cycle spacing
        push_frame(48, 0);
        push_frame(32, 128);
        drive_vld(256, 2);
        repeat (4) @(negedge clk);
        #3;
        chk("frames_drained", fq.size(), 0);

        // Overflow and clr
        @(negedge clk);
        event_fft_overflow = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf_set", int'(ovf_sticky), 1);
        chk("ovf_state_run", int'(state), 3);
        @(negedge clk);
        event_fft_overflow = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf_clr", int'(ovf_sticky), 0);
        @(negedge clk);
        event_fft_overflow = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf_set_wins", int'(ovf_sticky), 1);
        @(negedge clk);
        event_fft_overflow = 1'b0;
        clr = 1'b0;

        // Pause: en low for 20 cycles
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("pause_din_en", int'(din_en), 0);
            chk("pause_state", int'(state), 3);
        end
        chk("pause_phase", int'(phase), 32);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_din_en", int'(din_en), 1);

        // Fault in RUN
        @(negedge clk);
        event_tlast_missing = 1'b1;
        @(posedge clk);
        #1;
        chk("fault_din_en", int'(din_en), 0);
        chk("fault_hold_rst", int'(hold_rst), 1);
        chk("fault_state", int'(state), 0);
        chk("fault_err_count", int'(err_count), 1);
        chk("fault_phase", int'(phase), 0);
        @(negedge clk);
        event_tlast_missing = 1'b0;
        wait_flush(n);
        chk("reflush_len", n, 512);
        chk("reconfig_state", int'(state), 1);
        do_handshake(n);
        chk("recfg_to_din_en", n, 17);

        // Phase restarts from zero after re-sync
        push_frame(48, 0);
        drive_vld(64, 1);
        repeat (4) @(negedge clk);

        // Three fault flags in one cycle count once
        event_tlast_missing = 1'b1;
        event_tlast_unexpected = 1'b1;
        event_data_in_channel_halt = 1'b1;
        @(posedge clk);
        #1;
        chk("multi_fault_err_count", int'(err_count), 2);
        chk("multi_fault_state", int'(state), 0);
        @(negedge clk);
        event_tlast_missing = 1'b0;
        event_tlast_unexpected = 1'b0;
        event_data_in_channel_halt = 1'b0;
        repeat (2) @(negedge clk);
        #3;

        chk("sb_frames_left", fq.size(), 0);
        chk("sb_cfg_left", cq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
